// File: rtl/duck_bus_if.sv
// Shared request/done memory bus between duck_core (master) and the memory/IO arbiter (slave).
interface duck_bus_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] bus_address_out;
   logic [7:0]        bus_data_out;
   logic [7:0]        bus_data_in;
   logic              bus_read;
   logic              bus_write;
   logic              bus_done;

   modport master (
      output bus_address_out, bus_data_out, bus_read, bus_write,
      input  bus_data_in, bus_done
   );

   modport slave (
      input  bus_address_out, bus_data_out, bus_read, bus_write,
      output bus_data_in, bus_done
   );
endinterface

// File: rtl/duck_core.sv
// DuckCPU multi-cycle 8-bit core: fetch/decode/execute of a 16-opcode ISA over one request/done bus,
// with four GPRs, Z/C flags, loads/stores, conditional jumps, halt and a bus-timeout fault.
module duck_core #(
   parameter int                ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                BUS_TIMEOUT  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   duck_bus_if.master        bus,
   output logic              halted,
   output logic              fault,
   output logic [ADDR_W-1:0] dbg_ip
);
   localparam int          ABYTES = ADDR_W / 8;
   localparam logic [31:0] TMO    = 32'(BUS_TIMEOUT);

   localparam logic [3:0] OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB, OP_JC  = 4'hC;
   localparam logic [3:0] OP_INC = 4'hD, OP_CMP = 4'hE, OP_HLT = 4'hF;

   typedef enum logic [3:0] {
      S_FETCH, S_FETCH_WAIT, S_OPERAND, S_OPERAND_WAIT,
      S_MEM, S_MEM_WAIT, S_EXEC, S_HALT, S_FAULT
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ip;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] opaddr;
   logic [7:0]        wdata_q;
   logic [7:0]        insn;
   logic              rd_q;
   logic              wr_q;
   logic [1:0]        op_idx;
   logic [31:0]       wcnt;
   logic [7:0]        gpr [4];
   logic              zf;
   logic              cf;

   logic [3:0]        opc;
   logic [1:0]        rd;
   logic [1:0]        rs;
   logic [8:0]        alu_res;

   // Number of operand bytes that follow an opcode byte.
   function automatic logic [1:0] op_bytes(input logic [3:0] op);
      case (op)
         OP_LDI:                            op_bytes = 2'd1;
         OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC: op_bytes = 2'(ABYTES);
         default:                           op_bytes = 2'd0;
      endcase
   endfunction

   // Bit 8 carries carry-out for ADD/INC and borrow for SUB/CMP; logic ops clear it.
   function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         OP_ADD:         alu = {1'b0, a} + {1'b0, b};
         OP_SUB, OP_CMP: alu = {1'b0, a} - {1'b0, b};
         OP_AND:         alu = {1'b0, a & b};
         OP_OR:          alu = {1'b0, a | b};
         OP_XOR:         alu = {1'b0, a ^ b};
         OP_INC:         alu = {1'b0, a} + 9'd1;
         default:        alu = 9'd0;
      endcase
   endfunction

   assign opc     = insn[7:4];
   assign rd      = insn[3:2];
   assign rs      = insn[1:0];
   assign alu_res = alu(opc, gpr[rd], gpr[rs]);

   assign bus.bus_address_out = addr_q;
   assign bus.bus_data_out    = wdata_q;
   assign bus.bus_read        = rd_q;
   assign bus.bus_write       = wr_q;
   assign dbg_ip              = ip;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         ip      <= RESET_VECTOR;
         addr_q  <= '0;
         opaddr  <= '0;
         wdata_q <= 8'd0;
         insn    <= 8'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         op_idx  <= 2'd0;
         wcnt    <= 32'd0;
         zf      <= 1'b0;
         cf      <= 1'b0;
         halted  <= 1'b0;
         fault   <= 1'b0;
         for (int i = 0; i < 4; i++) gpr[i] <= 8'd0;
      end else begin
         case (state)
            S_FETCH: begin
               addr_q <= ip;
               rd_q   <= 1'b1;
               wcnt   <= 32'd0;
               state  <= S_FETCH_WAIT;
            end
            S_OPERAND: begin
               addr_q <= ip;
               rd_q   <= 1'b1;
               wcnt   <= 32'd0;
               state  <= S_OPERAND_WAIT;
            end
            S_MEM: begin
               addr_q <= opaddr;
               wcnt   <= 32'd0;
               if (opc == OP_ST) begin
                  wdata_q <= gpr[rd];
                  wr_q    <= 1'b1;
               end else begin
                  rd_q <= 1'b1;
               end
               state <= S_MEM_WAIT;
            end
            // All three wait states share completion and timeout handling.
            S_FETCH_WAIT, S_OPERAND_WAIT, S_MEM_WAIT: begin
               if (bus.bus_done) begin
                  rd_q <= 1'b0;
                  wr_q <= 1'b0;
                  if (state == S_FETCH_WAIT) begin
                     insn   <= bus.bus_data_in;
                     ip     <= ip + 1'b1;
                     op_idx <= 2'd0;
                     opaddr <= '0;
                     state  <= (op_bytes(bus.bus_data_in[7:4]) != 2'd0) ? S_OPERAND : S_EXEC;
                  end else if (state == S_OPERAND_WAIT) begin
                     opaddr <= opaddr | (ADDR_W'(bus.bus_data_in) << {op_idx, 3'b000});
                     ip     <= ip + 1'b1;
                     op_idx <= op_idx + 2'd1;
                     if (op_idx + 2'd1 == op_bytes(opc))
                        state <= (opc == OP_LD || opc == OP_ST) ? S_MEM : S_EXEC;
                     else
                        state <= S_OPERAND;
                  end else begin
                     if (opc == OP_LD) gpr[rd] <= bus.bus_data_in;
                     state <= S_EXEC;
                  end
               end else if (TMO != 32'd0 && wcnt == TMO - 32'd1) begin
                  rd_q  <= 1'b0;
                  wr_q  <= 1'b0;
                  fault <= 1'b1;
                  state <= S_FAULT;
               end else begin
                  wcnt <= wcnt + 32'd1;
               end
            end
            S_EXEC: begin
               case (opc)
                  OP_LDI: gpr[rd] <= opaddr[7:0];
                  OP_MOV: gpr[rd] <= gpr[rs];
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC: begin
                     gpr[rd] <= alu_res[7:0];
                     cf      <= alu_res[8];
                     zf      <= (alu_res[7:0] == 8'd0);
                  end
                  OP_CMP: begin
                     cf <= alu_res[8];
                     zf <= (alu_res[7:0] == 8'd0);
                  end
                  OP_JMP: ip <= opaddr;
                  OP_JZ:  if (zf) ip <= opaddr;
                  OP_JC:  if (cf) ip <= opaddr;
                  default: ;
               endcase
               if (opc == OP_HLT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_HALT, S_FAULT: ;
            default: state <= S_FETCH;
         endcase
      end
   end
endmodule
